// File: rtl/ccip_pipe_skid.sv
// CCI-P register pipeline: Rx/Tx retiming plus per-channel Tx skid FIFOs that absorb
// requests still in flight when almost-full is regenerated toward the AFU.
module ccip_pipe_skid #(
    parameter int unsigned RX_W        = 700,
    parameter int unsigned DATA_W      = 640,
    parameter int unsigned N_CH        = 3,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned SKID_DEPTH  = 16,
    localparam int unsigned LW         = $clog2(SKID_DEPTH + 1)
) (
    input  logic                     pClk,
    input  logic                     pck_cp2af_softReset_n,
    input  logic [RX_W-1:0]          rx_in,
    output logic [RX_W-1:0]          rx_out,
    input  logic [N_CH-1:0]          tx_in_valid,
    input  logic [N_CH*DATA_W-1:0]   tx_in_data,
    output logic [N_CH-1:0]          tx_in_almfull,
    output logic [N_CH-1:0]          tx_out_valid,
    output logic [N_CH*DATA_W-1:0]   tx_out_data,
    input  logic [N_CH-1:0]          tx_out_almfull,
    output logic [N_CH*LW-1:0]       skid_level,
    output logic [N_CH-1:0]          ovf_err
);

    localparam int unsigned PW     = $clog2(SKID_DEPTH);
    localparam int          THRESH = int'(SKID_DEPTH) - 2 * int'(PIPE_STAGES) - 2;

    logic [N_CH-1:0]        ing_valid;
    logic [N_CH*DATA_W-1:0] ing_data;
    logic [N_CH-1:0]        almfull_dly;

    generate
        if (PIPE_STAGES == 0) begin : g_comb
            assign rx_out      = rx_in;
            assign ing_valid   = tx_in_valid;
            assign ing_data    = tx_in_data;
            assign almfull_dly = tx_out_almfull;
        end else begin : g_pipe
            logic [RX_W-1:0]        rx_q    [PIPE_STAGES];
            logic [N_CH-1:0]        vld_q   [PIPE_STAGES];
            logic [N_CH*DATA_W-1:0] dat_q   [PIPE_STAGES];
            logic [N_CH-1:0]        almf_q  [PIPE_STAGES];

            // Almfull stages reset high so the AFU stays throttled until the delay line fills.
            always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
                if (!pck_cp2af_softReset_n) begin
                    for (int i = 0; i < PIPE_STAGES; i++) begin
                        rx_q[i]   <= '0;
                        vld_q[i]  <= '0;
                        dat_q[i]  <= '0;
                        almf_q[i] <= '1;
                    end
                end else begin
                    rx_q[0]   <= rx_in;
                    vld_q[0]  <= tx_in_valid;
                    dat_q[0]  <= tx_in_data;
                    almf_q[0] <= tx_out_almfull;
                    for (int i = 1; i < PIPE_STAGES; i++) begin
                        rx_q[i]   <= rx_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                        dat_q[i]  <= dat_q[i-1];
                        almf_q[i] <= almf_q[i-1];
                    end
                end
            end

            assign rx_out      = rx_q[PIPE_STAGES-1];
            assign ing_valid   = vld_q[PIPE_STAGES-1];
            assign ing_data    = dat_q[PIPE_STAGES-1];
            assign almfull_dly = almf_q[PIPE_STAGES-1];
        end
    endgenerate

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [SKID_DEPTH];
        logic [PW-1:0]     wr_ptr_q;
        logic [PW-1:0]     rd_ptr_q;
        logic [LW-1:0]     level_q;
        logic              out_valid_q;
        logic [DATA_W-1:0] out_data_q;
        logic              ovf_q;
        logic              full;
        logic              pop;
        logic              push;

        // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
        always_comb begin
            full = (level_q == LW'(SKID_DEPTH));
            pop  = (level_q != '0) && !tx_out_almfull[c];
            push = ing_valid[c] && (!full || pop);
        end

        always_ff @(posedge pClk) begin
            if (push) begin
                mem[wr_ptr_q] <= ing_data[c*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
            if (!pck_cp2af_softReset_n) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                level_q     <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                ovf_q       <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
                if (ing_valid[c] && full && !pop) ovf_q <= 1'b1;
                out_valid_q <= pop;
                if (pop) out_data_q <= mem[rd_ptr_q];
            end
        end

        assign tx_out_valid[c]                   = out_valid_q;
        assign tx_out_data[c*DATA_W +: DATA_W]   = out_data_q;
        assign skid_level[c*LW +: LW]            = level_q;
        assign ovf_err[c]                        = ovf_q;
        assign tx_in_almfull[c] = almfull_dly[c] | (level_q >= LW'(THRESH));
    end

endmodule

// File: tb/tb_ccip_pipe_skid.sv
// Directed bench for ccip_pipe_skid: a PIPE_STAGES=2 instance and a PIPE_STAGES=0 instance.
module tb_ccip_pipe_skid;

    localparam int RW  = 700;
    localparam int DW  = 640;
    localparam int LW  = 5;
    localparam int RW0 = 16;
    localparam int DW0 = 16;
    localparam int LW0 = 4;

    logic              clk;
    logic              rst_n;
    logic [RW-1:0]     rx_in, rx_out;
    logic [2:0]        tx_in_valid, tx_in_almfull, tx_out_valid, tx_out_almfull, ovf_err;
    logic [3*DW-1:0]   tx_in_data, tx_out_data;
    logic [3*LW-1:0]   skid_level;

    logic [RW0-1:0]    rx_in0, rx_out0;
    logic [2:0]        tx_in_valid0, tx_in_almfull0, tx_out_valid0, tx_out_almfull0, ovf_err0;
    logic [3*DW0-1:0]  tx_in_data0, tx_out_data0;
    logic [3*LW0-1:0]  skid_level0;

    int n_pass;
    int n_total;

    ccip_pipe_skid #(.RX_W(RW), .DATA_W(DW), .N_CH(3), .PIPE_STAGES(2), .SKID_DEPTH(16)) u_dut (
        .pClk(clk), .pck_cp2af_softReset_n(rst_n), .rx_in(rx_in), .rx_out(rx_out),
        .tx_in_valid(tx_in_valid), .tx_in_data(tx_in_data), .tx_in_almfull(tx_in_almfull),
        .tx_out_valid(tx_out_valid), .tx_out_data(tx_out_data), .tx_out_almfull(tx_out_almfull),
        .skid_level(skid_level), .ovf_err(ovf_err)
    );

    ccip_pipe_skid #(.RX_W(RW0), .DATA_W(DW0), .N_CH(3), .PIPE_STAGES(0), .SKID_DEPTH(8)) u_dut0 (
        .pClk(clk), .pck_cp2af_softReset_n(rst_n), .rx_in(rx_in0), .rx_out(rx_out0),
        .tx_in_valid(tx_in_valid0), .tx_in_data(tx_in_data0), .tx_in_almfull(tx_in_almfull0),
        .tx_out_valid(tx_out_valid0), .tx_out_data(tx_out_data0),
        .tx_out_almfull(tx_out_almfull0), .skid_level(skid_level0), .ovf_err(ovf_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] out_d(input int c);
        return tx_out_data[c*DW +: DW];
    endfunction

    function automatic logic [LW-1:0] lvl(input int c);
        return skid_level[c*LW +: LW];
    endfunction

    task automatic set_req(input int c, input logic [DW-1:0] d);
        tx_in_valid[c]         = 1'b1;
        tx_in_data[c*DW +: DW] = d;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_total++; if (tx_in_almfull !== 3'b111) $display("FAIL rst_almfull: got %b want 111", tx_in_almfull); else n_pass++;
        n_total++; if (tx_out_valid !== 3'b000) $display("FAIL rst_valid: got %b want 000", tx_out_valid); else n_pass++;
        n_total++; if (skid_level !== '0) $display("FAIL rst_level: got %h want 0", skid_level); else n_pass++;
        n_total++; if (ovf_err !== 3'b000) $display("FAIL rst_ovf: got %b want 000", ovf_err); else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++; if (tx_in_almfull !== 3'b111) $display("FAIL rel_almfull_c1: got %b want 111", tx_in_almfull); else n_pass++;
        step();
        n_total++; if (tx_in_almfull !== 3'b000) $display("FAIL rel_almfull_c2: got %b want 000", tx_in_almfull); else n_pass++;
    endtask

    task automatic test_latency();
        rx_in = RW'(12'h123);
        set_req(1, DW'(8'hA5));
        step();
        rx_in       = '0;
        tx_in_valid = '0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            n_total++;
            if (tx_out_valid[1] !== (cyc == 4))
                $display("FAIL lat_valid_c%0d: got %b want %b", cyc, tx_out_valid[1], cyc == 4);
            else n_pass++;
            if (cyc == 2) begin
                n_total++; if (rx_out !== RW'(12'h123)) $display("FAIL rx_lat: got %h want 123", rx_out); else n_pass++;
            end
            if (cyc == 3) begin
                n_total++; if (rx_out !== '0) $display("FAIL rx_after: got %h want 0", rx_out); else n_pass++;
            end
            if (cyc == 4) begin
                n_total++; if (out_d(1) !== DW'(8'hA5)) $display("FAIL lat_data: got %h want a5", out_d(1)); else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic seen;
        seen = 1'b0;
        tx_out_almfull = 3'b001;
        for (int i = 0; i < 10; i++) begin
            set_req(0, DW'(12'h100) + DW'(i));
            step();
            seen |= tx_out_valid[0];
        end
        tx_in_valid = '0;
        repeat (3) begin
            step();
            seen |= tx_out_valid[0];
        end
        n_total++; if (seen !== 1'b0) $display("FAIL bp_issued: got %b want 0", seen); else n_pass++;
        n_total++; if (lvl(0) !== LW'(10)) $display("FAIL bp_level: got %0d want 10", lvl(0)); else n_pass++;
        n_total++; if (tx_in_almfull[0] !== 1'b1) $display("FAIL bp_almfull: got %b want 1", tx_in_almfull[0]); else n_pass++;
        tx_out_almfull = 3'b000;
        for (int k = 0; k < 10; k++) begin
            step();
            n_total++;
            if (tx_out_valid[0] !== 1'b1 || out_d(0) !== DW'(12'h100) + DW'(k))
                $display("FAIL bp_drain_%0d: got v=%b d=%h want v=1 d=%h", k, tx_out_valid[0], out_d(0), DW'(12'h100) + DW'(k));
            else n_pass++;
        end
        step();
        n_total++; if (tx_out_valid[0] !== 1'b0) $display("FAIL bp_idle: got %b want 0", tx_out_valid[0]); else n_pass++;
        n_total++; if (lvl(0) !== '0) $display("FAIL bp_level_end: got %0d want 0", lvl(0)); else n_pass++;
        n_total++; if (tx_in_almfull[0] !== 1'b0) $display("FAIL bp_almfull_end: got %b want 0", tx_in_almfull[0]); else n_pass++;
    endtask

    task automatic test_overflow();
        tx_out_almfull = 3'b001;
        for (int i = 0; i < 17; i++) begin
            set_req(0, DW'(12'h200) + DW'(i));
            step();
        end
        tx_in_valid = '0;
        repeat (3) step();
        n_total++; if (lvl(0) !== LW'(16)) $display("FAIL ovf_level: got %0d want 16", lvl(0)); else n_pass++;
        n_total++; if (ovf_err !== 3'b001) $display("FAIL ovf_flag: got %b want 001", ovf_err); else n_pass++;
        tx_out_almfull = 3'b000;
        for (int k = 0; k < 16; k++) begin
            step();
            n_total++;
            if (tx_out_valid[0] !== 1'b1 || out_d(0) !== DW'(12'h200) + DW'(k))
                $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", k, tx_out_valid[0], out_d(0), DW'(12'h200) + DW'(k));
            else n_pass++;
            // Delayed almfull has cleared here; only the level threshold (14 >= 10) holds it.
            if (k == 1) begin
                n_total++; if (tx_in_almfull[0] !== 1'b1) $display("FAIL thresh_almfull: got %b want 1", tx_in_almfull[0]); else n_pass++;
            end
        end
        step();
        n_total++; if (tx_out_valid[0] !== 1'b0) $display("FAIL ovf_idle: got %b want 0", tx_out_valid[0]); else n_pass++;
        n_total++; if (ovf_err[0] !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf_err[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_traffic();
        tx_out_almfull = 3'b001;
        for (int i = 0; i < 4; i++) begin
            set_req(0, DW'(12'h400) + DW'(i));
            step();
        end
        tx_in_valid = '0;
        repeat (3) step();
        n_total++; if (lvl(0) !== LW'(4)) $display("FAIL mid_level: got %0d want 4", lvl(0)); else n_pass++;
        tx_out_almfull = 3'b000;
        step();
        n_total++; if (tx_out_valid[0] !== 1'b1) $display("FAIL mid_valid: got %b want 1", tx_out_valid[0]); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (tx_out_valid !== 3'b000) $display("FAIL mid_rst_valid: got %b want 000", tx_out_valid); else n_pass++;
        n_total++; if (skid_level !== '0) $display("FAIL mid_rst_level: got %h want 0", skid_level); else n_pass++;
        n_total++; if (tx_in_almfull !== 3'b111) $display("FAIL mid_rst_almfull: got %b want 111", tx_in_almfull); else n_pass++;
        n_total++; if (ovf_err !== 3'b000) $display("FAIL mid_rst_ovf: got %b want 000", ovf_err); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_total++; if (tx_in_almfull !== 3'b111) $display("FAIL mid_rel_c1: got %b want 111", tx_in_almfull); else n_pass++;
        step();
        n_total++; if (tx_in_almfull !== 3'b000) $display("FAIL mid_rel_c2: got %b want 000", tx_in_almfull); else n_pass++;
        n_total++; if (tx_out_valid !== 3'b000 || skid_level !== '0)
            $display("FAIL mid_rel_quiet: got v=%b l=%h want v=000 l=0", tx_out_valid, skid_level); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp;
        tx_out_almfull = 3'b001;
        for (int i = 0; i < 16; i++) begin
            set_req(0, DW'(12'h300) + DW'(i));
            step();
        end
        tx_in_valid = '0;
        repeat (2) step();
        n_total++; if (lvl(0) !== LW'(16)) $display("FAIL fpp_full: got %0d want 16", lvl(0)); else n_pass++;
        set_req(0, DW'(12'h3FF));
        step();
        tx_in_valid = '0;
        step();
        tx_out_almfull = 3'b000;
        step();
        n_total++; if (lvl(0) !== LW'(16)) $display("FAIL fpp_level: got %0d want 16", lvl(0)); else n_pass++;
        n_total++; if (ovf_err[0] !== 1'b0) $display("FAIL fpp_ovf: got %b want 0", ovf_err[0]); else n_pass++;
        n_total++; if (tx_out_valid[0] !== 1'b1 || out_d(0) !== DW'(12'h300))
            $display("FAIL fpp_first: got v=%b d=%h want v=1 d=300", tx_out_valid[0], out_d(0)); else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = (k < 16) ? DW'(12'h300) + DW'(k) : DW'(12'h3FF);
            n_total++;
            if (tx_out_valid[0] !== 1'b1 || out_d(0) !== exp)
                $display("FAIL fpp_drain_%0d: got v=%b d=%h want v=1 d=%h", k, tx_out_valid[0], out_d(0), exp);
            else n_pass++;
        end
        step();
        n_total++; if (tx_out_valid[0] !== 1'b0 || lvl(0) !== '0 || ovf_err[0] !== 1'b0)
            $display("FAIL fpp_end: got v=%b l=%0d o=%b want 0/0/0", tx_out_valid[0], lvl(0), ovf_err[0]); else n_pass++;
    endtask

    task automatic test_pipe0();
        rx_in0 = 16'h0123;
        #1;
        n_total++; if (rx_out0 !== 16'h0123) $display("FAIL p0_rx_a: got %h want 0123", rx_out0); else n_pass++;
        rx_in0 = 16'hBEEF;
        #1;
        n_total++; if (rx_out0 !== 16'hBEEF) $display("FAIL p0_rx_b: got %h want beef", rx_out0); else n_pass++;
        step();
        tx_out_almfull0 = 3'b100;
        tx_in_valid0    = 3'b101;
        tx_in_data0     = {16'h0022, 16'h0000, 16'h0011};
        step();
        n_total++; if (tx_out_valid0 !== 3'b000) $display("FAIL p0_c1_valid: got %b want 000", tx_out_valid0); else n_pass++;
        n_total++; if (tx_in_almfull0 !== 3'b100) $display("FAIL p0_almfull: got %b want 100", tx_in_almfull0); else n_pass++;
        tx_in_data0 = {16'h0023, 16'h0000, 16'h0012};
        step();
        tx_in_valid0 = 3'b000;
        n_total++; if (tx_out_valid0 !== 3'b001 || tx_out_data0[15:0] !== 16'h0011)
            $display("FAIL p0_c2: got v=%b d=%h want v=001 d=0011", tx_out_valid0, tx_out_data0[15:0]); else n_pass++;
        step();
        n_total++; if (tx_out_valid0 !== 3'b001 || tx_out_data0[15:0] !== 16'h0012)
            $display("FAIL p0_c3: got v=%b d=%h want v=001 d=0012", tx_out_valid0, tx_out_data0[15:0]); else n_pass++;
        step();
        n_total++; if (tx_out_valid0 !== 3'b000) $display("FAIL p0_c4_valid: got %b want 000", tx_out_valid0); else n_pass++;
        n_total++; if (skid_level0 !== {4'd2, 4'd0, 4'd0}) $display("FAIL p0_levels: got %h want 200", skid_level0); else n_pass++;
        tx_out_almfull0 = 3'b000;
        step();
        n_total++; if (tx_out_valid0 !== 3'b100 || tx_out_data0[47:32] !== 16'h0022)
            $display("FAIL p0_ch2_a: got v=%b d=%h want v=100 d=0022", tx_out_valid0, tx_out_data0[47:32]); else n_pass++;
        step();
        n_total++; if (tx_out_valid0 !== 3'b100 || tx_out_data0[47:32] !== 16'h0023)
            $display("FAIL p0_ch2_b: got v=%b d=%h want v=100 d=0023", tx_out_valid0, tx_out_data0[47:32]); else n_pass++;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst_n           = 1'b0;
        rx_in           = '0;
        tx_in_valid     = '0;
        tx_in_data      = '0;
        tx_out_almfull  = '0;
        rx_in0          = '0;
        tx_in_valid0    = '0;
        tx_in_data0     = '0;
        tx_out_almfull0 = '0;
        test_reset();
        test_latency();
        test_backpressure();
        test_overflow();
        test_reset_mid_traffic();
        test_full_push_pop();
        test_pipe0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
